// File: rtl/padding_frame_scheduler_pkg.sv
// rtl/padding_frame_scheduler_pkg.sv - shared hyper-parameters, frame-size helper and FSM state encoding
//   Contents: default image geometry and channel count, padded-frame size
//   function, and the scheduler state type used by the top module.
package padding_frame_scheduler_pkg;

    localparam int DEF_IMG_W  = 32;
    localparam int DEF_IMG_H  = 32;
    localparam int DEF_CH_NUM = 3;
    localparam int DEF_ADDR_W = 16;

    // One pixel of zero padding on every side of the image.
    function automatic int frame_pixels(input int w, input int h);
        return (w + 2) * (h + 2);
    endfunction

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_CH_END = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/padding_frame_scheduler_pad_frame_counter.sv
// rtl/padding_frame_scheduler_pad_frame_counter.sv - padded-pixel and read counters with last/mismatch compare
//   Ports:
//     s_clk, s_rst_n   clock, asynchronous active-low reset
//     i_clear          zero both counters (scheduler LOAD state)
//     i_pix_inc        accepted padded pixel this cycle
//     i_rd_inc         feature RAM read issued this cycle
//     o_pix_last       this cycle's accepted pixel is the last of the padded frame
//     o_rd_mismatch    read count, including this cycle's read, differs from IMG_W*IMG_H
module pad_frame_counter
    import padding_frame_scheduler_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic s_clk,
    input  logic s_rst_n,
    input  logic i_clear,
    input  logic i_pix_inc,
    input  logic i_rd_inc,
    output logic o_pix_last,
    output logic o_rd_mismatch
);

    localparam int FRAME_PIX = frame_pixels(IMG_W, IMG_H);
    localparam int RD_TOTAL  = IMG_W * IMG_H;
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);

    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] w_rd_next;

    // The compare looks at the count after this cycle so a read coinciding
    // with the last pixel is still counted when the channel closes.
    assign w_rd_next     = r_rd_cnt + CNT_W'(i_rd_inc);
    assign o_rd_mismatch = (w_rd_next != CNT_W'(RD_TOTAL));
    assign o_pix_last    = i_pix_inc && (r_pix_cnt == CNT_W'(FRAME_PIX - 1));

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_pix_cnt <= '0;
            r_rd_cnt  <= '0;
        end else if (i_clear) begin
            r_pix_cnt <= '0;
            r_rd_cnt  <= '0;
        end else begin
            if (i_pix_inc) begin
                r_pix_cnt <= r_pix_cnt + CNT_W'(1);
            end
            if (i_rd_inc) begin
                r_rd_cnt <= w_rd_next;
            end
        end
    end

endmodule

// File: rtl/padding_frame_scheduler.sv
// rtl/padding_frame_scheduler.sv - per-channel padded-frame scheduler between padding unit, feature RAM and PE array
//   Ports:
//     s_clk, s_rst_n        clock, asynchronous active-low reset
//     i_start, i_abort      pass start pulse (IDLE only), synchronous abort
//     i_pe_ready            PE array back-pressure
//     o_ready4data          ready to padding unit (pe_ready while streaming)
//     i_pad_valid, i_rd_req padded-pixel valid, interior-pixel read request
//     o_rd_en, o_rd_addr    feature RAM read port
//     o_ch_idx              channel being streamed
//     o_frame_last          last accepted padded pixel of a channel
//     o_busy, o_done, o_err pass in progress, completion pulse, sticky read-count error
module padding_frame_scheduler
    import padding_frame_scheduler_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int CH_NUM = DEF_CH_NUM,
    parameter int ADDR_W = DEF_ADDR_W,
    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_pe_ready,
    output logic              o_ready4data,
    input  logic              i_pad_valid,
    input  logic              i_rd_req,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [CH_W-1:0]   o_ch_idx,
    output logic              o_frame_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [ADDR_W-1:0] CH_STRIDE = ADDR_W'(IMG_W * IMG_H);

    state_t            r_state;
    logic [CH_W-1:0]   r_ch_idx;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_err;

    logic              w_run;
    logic              w_accept;
    logic              w_rd_en;
    logic              w_pix_last;
    logic              w_rd_mismatch;
    logic [ADDR_W-1:0] w_base;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = i_pad_valid && i_pe_ready && w_run;
    assign w_rd_en  = i_rd_req && i_pe_ready && w_run;
    // Wraps modulo 2^ADDR_W by construction.
    assign w_base   = ADDR_W'(r_ch_idx) * CH_STRIDE;

    pad_frame_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_counter (
        .s_clk         (s_clk),
        .s_rst_n       (s_rst_n),
        .i_clear       (r_state == S_LOAD),
        .i_pix_inc     (w_accept),
        .i_rd_inc      (w_rd_en),
        .o_pix_last    (w_pix_last),
        .o_rd_mismatch (w_rd_mismatch)
    );

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state   <= S_IDLE;
            r_ch_idx  <= '0;
            r_rd_addr <= '0;
            r_err     <= 1'b0;
        end else if (i_abort) begin
            r_state <= S_IDLE;
        end else begin
            if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state  <= S_LOAD;
                        r_ch_idx <= '0;
                        r_err    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_rd_addr <= w_base;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (w_pix_last) begin
                        r_state <= S_CH_END;
                        if (w_rd_mismatch) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_CH_END: begin
                    if (r_ch_idx < CH_W'(CH_NUM - 1)) begin
                        r_ch_idx <= r_ch_idx + CH_W'(1);
                        r_state  <= S_LOAD;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready4data = i_pe_ready && w_run;
    assign o_rd_en      = w_rd_en;
    assign o_rd_addr    = r_rd_addr;
    assign o_ch_idx     = r_ch_idx;
    assign o_frame_last = w_pix_last;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_err        = r_err;

endmodule

// File: tb/tb_padding_frame_scheduler.sv
// tb/tb_padding_frame_scheduler.sv - scoreboard bench for padding_frame_scheduler with a random padding-unit model
module tb_padding_frame_scheduler;

    localparam int W      = 4;
    localparam int H      = 4;
    localparam int CH     = 2;
    localparam int AW     = 16;
    localparam int FRAME  = (W + 2) * (H + 2);
    localparam int RD_TOT = W * H;

    logic          s_clk = 1'b0;
    logic          s_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_pe_ready = 1'b0;
    logic          i_pad_valid = 1'b0;
    logic          i_rd_req = 1'b0;
    logic          o_ready4data;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [0:0]    o_ch_idx;
    logic          o_frame_last;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    int checks = 0;
    int errors = 0;
    int exp_addr[$];
    int exp_last[$];
    int exp_done[$];
    int exp_err_ch[CH];

    always #5 s_clk = ~s_clk;

    padding_frame_scheduler #(
        .IMG_W (W),
        .IMG_H (H),
        .CH_NUM(CH),
        .ADDR_W(AW)
    ) dut (
        .s_clk        (s_clk),
        .s_rst_n      (s_rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_pe_ready   (i_pe_ready),
        .o_ready4data (o_ready4data),
        .i_pad_valid  (i_pad_valid),
        .i_rd_req     (i_rd_req),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .o_ch_idx     (o_ch_idx),
        .o_frame_last (o_frame_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    // Padded-frame pixel p (raster order) carries image data when it is not on the border.
    function automatic bit interior(input int p);
        int r = p / (W + 2);
        int c = p % (W + 2);
        return (r >= 1) && (r <= H) && (c >= 1) && (c <= W);
    endfunction

    // Scoreboard monitor: every presented DUT event must match the next expectation.
    always @(negedge s_clk) begin
        if (o_rd_en) begin
            if (exp_addr.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_addr", 32'(o_rd_addr), exp_addr.pop_front());
        end
        if (o_frame_last) begin
            if (exp_last.size() == 0) chk("last_unexpected", 1, 0);
            else chk("last_ch", 32'(o_ch_idx), exp_last.pop_front());
        end
        if (o_done) begin
            if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_err", 32'(o_err), exp_done.pop_front());
        end
    end

    task automatic reset_zero(input string name);
        chk(name, {o_busy, o_done, o_err, o_frame_last, o_ready4data, o_rd_en, o_rd_addr, o_ch_idx}, 0);
    endtask

    // cut_ch < 0: full pass. Otherwise abort (or reset if cut_rst) when cut_pix pixels of cut_ch are accepted.
    task automatic run_pass(input int rd_lim0, input int stall_ch, input int stall_pix,
                            input int cut_ch, input int cut_pix, input bit cut_rst, input int dstart_pix);
        int p, c, reads, lim, stall_left, k, npix, exp_err;
        bit stall_done, dstart_done, fin, acc;
        exp_err = 0;
        for (int ch = 0; ch < CH; ch++) begin
            if (cut_ch >= 0 && ch > cut_ch) break;
            npix = (ch == cut_ch) ? cut_pix : FRAME;
            lim  = (ch == 0) ? rd_lim0 : RD_TOT;
            k = 0;
            for (int q = 0; q < npix; q++) begin
                if (interior(q) && k < lim) begin
                    exp_addr.push_back((ch * RD_TOT + k) % (1 << AW));
                    k++;
                end
            end
            if (npix == FRAME) begin
                exp_last.push_back(ch);
                if (k != RD_TOT) exp_err = 1;
                exp_err_ch[ch] = exp_err;
            end
        end
        if (cut_ch < 0) exp_done.push_back(exp_err);

        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_busy", 32'(o_busy), 1);
        chk("start_err_clear", 32'(o_err), 0);

        p = 0; c = 0; reads = 0; stall_left = 0;
        stall_done = 0; dstart_done = 0; fin = 0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            lim = (c == 0) ? rd_lim0 : RD_TOT;
            i_start = 1'b0;
            i_abort = 1'b0;
            if (c == stall_ch && p == stall_pix && !stall_done) begin
                stall_left = 5;
                stall_done = 1;
            end
            i_pe_ready  = (stall_left > 0) ? 1'b0 : (($urandom % 4) != 0);
            i_pad_valid = (($urandom % 4) != 0);
            i_rd_req    = i_pad_valid && interior(p) && (reads < lim);
            if (c == 0 && p == dstart_pix && !dstart_done) begin
                i_start = 1'b1;
                dstart_done = 1;
            end
            if (c == cut_ch && p == cut_pix) begin
                i_pad_valid = 1'b0;
                i_rd_req    = 1'b0;
                if (cut_rst) begin
                    s_rst_n = 1'b0;
                    #1;
                    reset_zero("rst_async_zero");
                    tick();
                    tick();
                    s_rst_n = 1'b1;
                    for (int i = 0; i < 5; i++) begin
                        i_pe_ready = 1'b1; i_pad_valid = 1'b1; i_rd_req = 1'b1;
                        #1;
                        chk("post_rst_busy", 32'(o_busy), 0);
                        chk("post_rst_ready", 32'(o_ready4data), 0);
                        tick();
                    end
                    i_pad_valid = 1'b0; i_rd_req = 1'b0;
                end else begin
                    i_abort = 1'b1;
                    tick();
                    i_abort = 1'b0;
                    chk("abort_idle", 32'(o_busy), 0);
                end
                fin = 1;
            end else begin
                #1;
                acc = i_pad_valid && o_ready4data;
                if (stall_left > 0) begin
                    chk("stall_ready", 32'(o_ready4data), 0);
                    chk("stall_addr", 32'(o_rd_addr), c * RD_TOT + reads);
                end
                tick();
                if (stall_left > 0) stall_left--;
                if (acc) begin
                    if (i_rd_req) reads++;
                    if (p == FRAME - 1) begin
                        chk("ch_end_err", 32'(o_err), exp_err_ch[c]);
                        p = 0; c++; reads = 0;
                    end else begin
                        p++;
                    end
                end
                if (o_done) begin
                    tick();
                    chk("done_to_idle", 32'(o_busy), 0);
                    fin = 1;
                end
            end
        end
        if (!fin) chk("pass_timeout", 0, 1);
        i_start = 1'b0; i_abort = 1'b0; i_pad_valid = 1'b0; i_rd_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        tick();
        tick();
        reset_zero("reset_state");
        s_rst_n = 1'b1;
        tick();
        reset_zero("idle_after_release");

        run_pass(RD_TOT, -1, 0, -1, 0, 0, -1);   // nominal
        run_pass(RD_TOT, 0, 14, -1, 0, 0, -1);   // stall mid-frame
        run_pass(RD_TOT - 1, -1, 0, -1, 0, 0, -1); // read mismatch
        run_pass(RD_TOT, -1, 0, -1, 0, 0, -1);   // error cleared
        run_pass(RD_TOT, -1, 0, 1, 20, 0, -1);   // abort
        run_pass(RD_TOT, -1, 0, -1, 0, 0, -1);   // restart at address 0
        run_pass(RD_TOT, -1, 0, 0, 10, 1, -1);   // reset mid-pass
        run_pass(RD_TOT, 1, 7, -1, 0, 0, -1);    // nominal plus stall in ch1
        run_pass(RD_TOT, -1, 0, -1, 0, 0, 5);    // start while busy

        chk("addr_queue_empty", exp_addr.size(), 0);
        chk("last_queue_empty", exp_last.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/padding_frame_scheduler.md
PADDING_FRAME_SCHEDULER -- requirements
Module: padding_frame_scheduler

Interface
REQ-001 Parameter IMG_W, default 32, unpadded image width in pixels.
REQ-002 Parameter IMG_H, default 32, unpadded image height in pixels.
REQ-003 Parameter CH_NUM, default 3, number of channels per pass.
REQ-004 Parameter ADDR_W, default 16, feature RAM address width.
REQ-005 s_clk  input  1  single clock; all logic is on its rising edge.
REQ-006 s_rst_n  input  1  reset, asynchronous and active-low.
REQ-007 i_start  input  1  one-cycle pulse that begins a pass over all channels.
REQ-008 i_abort  input  1  synchronous abort of the current pass.
REQ-009 i_pe_ready  input  1  PE array can accept a padded pixel.
REQ-010 o_ready4data  output  1  ready4data drive to the padding unit.
REQ-011 i_pad_valid  input  1  padded-pixel valid from the padding unit.
REQ-012 i_rd_req  input  1  interior-pixel request from the padding unit.
REQ-013 o_rd_en  output  1  feature RAM read enable.
REQ-014 o_rd_addr  output  ADDR_W  feature RAM read address.
REQ-015 o_ch_idx  output  clog2(CH_NUM)  channel currently being streamed.
REQ-016 o_frame_last  output  1  pulse on the last padded pixel of a channel.
REQ-017 o_busy  output  1  pass in progress.
REQ-018 o_done  output  1  one-cycle pulse when the pass completes.
REQ-019 o_err  output  1  sticky read-count mismatch flag.

Function
REQ-020 The FSM SHALL have five states: IDLE, LOAD, RUN, CH_END, DONE.
REQ-021 FSM transitions SHALL be:
- IDLE->LOAD on i_start.
- LOAD->RUN after 1 cycle.
- RUN->CH_END on the accepted pixel (W+2)*(H+2)-1.
- CH_END->LOAD if ch<CH_NUM-1, otherwise CH_END->DONE.
- DONE->IDLE after 1 cycle.
REQ-022 LOAD SHALL set base = ch*IMG_W*IMG_H, set o_rd_addr = base, clear the padded and read counters.
REQ-023 o_ready4data SHALL equal i_pe_ready AND state==RUN, combinationally.
REQ-024 Accepted pixel SHALL be defined as i_pad_valid & o_ready4data; only accepted pixels SHALL advance the padded counter.
REQ-025 o_rd_en SHALL equal i_rd_req & i_pe_ready & state==RUN; each cycle with o_rd_en high SHALL increment o_rd_addr and the read counter after the cycle.
REQ-026 While i_pe_ready is low, no counter or address SHALL change.
REQ-027 o_frame_last SHALL be high combinationally in the cycle of the final accepted pixel of each channel.
REQ-028 o_ch_idx SHALL increment on CH_END->LOAD and hold its value otherwise during a pass.
REQ-029 On entering CH_END, if the read count != IMG_W*IMG_H, o_err SHALL be set; o_err SHALL clear only on an accepted i_start.
REQ-030 o_busy SHALL be high in every state except IDLE.
REQ-031 o_done SHALL be high exactly in the DONE state.
REQ-032 i_start in any state other than IDLE SHALL be ignored.
REQ-033 i_abort SHALL return the FSM to IDLE on the next edge from any state, with no o_done; it SHALL take priority over i_start and all other transitions.
REQ-034 Address arithmetic SHALL be ADDR_W wide and wrap modulo 2^ADDR_W.
REQ-035 Pixel counters SHALL be sized to hold (W+2)*(H+2) without overflow.

Reset
REQ-036 While s_rst_n is low:
- state SHALL be IDLE.
- all counters, o_ch_idx and o_rd_addr SHALL be 0.
- o_busy, o_done, o_err and o_frame_last SHALL be 0.
- o_ready4data and o_rd_en SHALL be 0.
REQ-037 Reset asserted mid-pass SHALL abandon the pass immediately; no o_done SHALL follow reset release.

Structure
REQ-038 IMG_W/IMG_H defaults, frame-size constants and the state encoding SHALL live in the shared hyper-parameter include.
REQ-039 One sub-module, pad_frame_counter, SHALL hold the padded-pixel and read counters and the last/mismatch compare; the FSM and address generation SHALL stay in the top module.

Verification
REQ-040 The bench SHALL cover the following directed scenarios with IMG_W=IMG_H=4, CH_NUM=2:
- Nominal: i_start with i_pe_ready=1 and the padding unit model -> 36 accepted pixels per channel, o_rd_addr 0..15 then 16..31, o_frame_last twice, o_done once, o_err=0.
- Stall: i_pe_ready low for 5 cycles mid-frame -> o_ready4data=0, no address or counter change; the pass then completes with identical totals.
- Read mismatch: model issues 15 reads in channel 0 -> o_err=1 at CH_END, held through DONE, cleared by the next i_start.
- Abort: i_abort at pixel 20 of channel 1 -> IDLE next cycle, o_busy=0, no o_done; a new i_start restarts at address 0.
- Reset mid-pass: s_rst_n low at pixel 10 -> all outputs 0 asynchronously; after release, no activity until i_start.
- Start while busy: second i_start during RUN -> ignored, exactly one o_done.
